cacheline_adapter: RTL

Synthesizable bridge between the last-level cache's 256-bit line port and the banked memory's 64-bit burst port. It sits inside `cpu`, on the initiator side of the banked memory interface that the testbench's `banked_memory` answers. It turns one line read into a single burst request plus 4 returned beats, and one line write into 4 write beats. It returns a single-cycle response to the cache.

---
 rtl/cacheline_adapter.sv | 100 ++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges a 256-bit cache line port to a 4-beat 64-bit banked memory burst port.
// Optional ADAPTER_RADDR_CHECK_EN drops read beats whose bmem_raddr tag mismatches and raises sticky err.
module cacheline_adapter #(
  parameter int LINE_BITS   = 256,
  parameter int BEAT_BITS   = 64,
  parameter int OFFSET_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid,
  output logic                 err
);
  localparam int CW = $clog2(LINE_BITS / BEAT_BITS);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] line_q, line_d, rdata_q, rdata_d;
  logic err_q, err_d, beat_ok, last;
  assign last = &cnt_q;
`ifdef ADAPTER_RADDR_CHECK_EN
  assign beat_ok = bmem_rvalid && bmem_raddr == addr_q;
  assign err_d = err_q | (state_q == RD_DATA && bmem_rvalid && bmem_raddr != addr_q);
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign beat_ok = bmem_rvalid;
  assign err_d = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = dfp_write ? WR_DATA : dfp_read ? RD_REQ : IDLE;
      RD_REQ:  state_d = bmem_ready ? RD_DATA : RD_REQ;
      RD_DATA: state_d = (beat_ok && last) ? DONE : RD_DATA;
      WR_DATA: state_d = (bmem_ready && last) ? DONE : WR_DATA;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bmem_read  = state_q == RD_REQ;
    bmem_write = state_q == WR_DATA;
    dfp_resp   = state_q == DONE;
  end
  assign bmem_addr  = addr_q;
  assign bmem_wdata = line_q[cnt_q*BEAT_BITS +: BEAT_BITS];
  assign dfp_rdata  = rdata_q;
  assign err        = err_q;
  // read beats assemble in line_q; dfp_rdata only updates when the final beat lands
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && (dfp_write || dfp_read)) begin
      addr_d = dfp_addr & ADDR_MASK;
      cnt_d  = '0;
      if (dfp_write) line_d = dfp_wdata;
    end
    if (state_q == WR_DATA && bmem_ready) cnt_d = cnt_q + 1'b1;
    if (state_q == RD_DATA && beat_ok) begin
      line_d[cnt_q*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
      cnt_d = cnt_q + 1'b1;
      if (last) rdata_d = line_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule
